// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier on the reference clock.
// Pulses the PLL reset, waits for a stable lock, then releases core reset.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1048576
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked_async,
  input  logic       reinit_req,
  input  logic       clear_status,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       clocks_ok,
  output logic       lock_lost,
  output logic [7:0] retry_count,
  output logic [1:0] state_dbg
);

  localparam int unsigned M0 =
    (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
    RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned CMAX =
    (M0 > LOCK_TIMEOUT_CYCLES) ? M0 : LOCK_TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] PULSE_LAST = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST = 2'd0,
    S_WAIT    = 2'd1,
    S_STABLE  = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          retry_inc;
  logic          lost_set;
  logic          sync_q1;
  logic          locked_s;

  assign state_dbg = state;

  // Two-flop synchronizer for the raw PLL lock indication
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q1  <= pll_locked_async;
      locked_s <= sync_q1;
    end
  end

  // Next-state and shared cycle counter; counter restarts on every state entry
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    retry_inc = 1'b0;
    lost_set  = 1'b0;
    unique case (state)
      S_PLL_RST: begin
        if (cnt == PULSE_LAST) begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_WAIT: begin
        if (reinit_req) begin
          state_n = S_PLL_RST;
          cnt_n   = '0;
        end else if (locked_s) begin
          state_n = S_STABLE;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) begin
          state_n   = S_PLL_RST;
          cnt_n     = '0;
          retry_inc = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_STABLE: begin
        if (reinit_req) begin
          state_n = S_PLL_RST;
          cnt_n   = '0;
        end else if (!locked_s) begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_RUN: begin
        cnt_n = '0;
        if (!locked_s) begin
          state_n  = S_PLL_RST;
          lost_set = 1'b1;
        end else if (reinit_req) begin
          state_n = S_PLL_RST;
        end
      end
      default: begin
        state_n = S_PLL_RST;
        cnt_n   = '0;
      end
    endcase
  end

  // State register with outputs decoded from the state being entered
  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= S_PLL_RST;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      core_rst    <= 1'b1;
      clocks_ok   <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= 8'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pll_rst   <= (state_n == S_PLL_RST);
      core_rst  <= (state_n != S_RUN);
      clocks_ok <= (state_n == S_RUN);
      if (lost_set) begin
        lock_lost <= 1'b1;
      end else if (clear_status) begin
        lock_lost <= 1'b0;
      end
      if (retry_inc && (retry_count != 8'hFF)) begin
        retry_count <= retry_count + 8'd1;
      end
    end
  end

endmodule
